// File: rtl/tdd_pkg.sv
// tdd_pkg: shared types, constants and tag helper for the TDD frame gate
package tdd_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  localparam logic [7:0] TAG_MAGIC = 8'hA5;
  localparam int CNT_W_DEF = 24;
  localparam int DATA_W_DEF = 32;
  function automatic logic [31:0] tag_word(input logic [23:0] fn);
    return {TAG_MAGIC, fn};
  endfunction
endpackage

// File: rtl/tdd_win_cmp.sv
// tdd_win_cmp: half-open window test start <= cnt < end, empty when start >= end
module tdd_win_cmp #(
  parameter int W = 24
) (
  input  logic [W-1:0] start_i,
  input  logic [W-1:0] end_i,
  input  logic [W-1:0] cnt_i,
  output logic         active_o
);
  assign active_o = (cnt_i >= start_i) && (cnt_i < end_i);
endmodule

// File: rtl/tdd_frame_gate.sv
// tdd_frame_gate: sample-rate TDD frame timer with RX gating and TX window control; TDD_FRAME_TAG_EN tags the first RX-window word
module tdd_frame_gate
  import tdd_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  frame_len,
  input  logic [CNT_W-1:0]  rstart,
  input  logic [CNT_W-1:0]  rend,
  input  logic [CNT_W-1:0]  tstart,
  input  logic [CNT_W-1:0]  tend,
  input  logic [CNT_W-1:0]  frame_adj,
  input  logic              adj_req,
  output logic              adj_pending,
  input  logic              rx_ce_in,
  input  logic [DATA_W-1:0] rx_din,
  output logic              rx_ce_out,
  output logic [DATA_W-1:0] rx_dout,
  output logic              tx_ce_out,
  output logic              tx_rx,
  output logic              frame_sync,
  output logic [CNT_W-1:0]  frame_no
);
  state_e state_q;
  logic [CNT_W-1:0] cnt_q, frame_no_q, last_q, adj_q;
  logic [CNT_W-1:0] rstart_q, rend_q, tstart_q, tend_q;
  logic adj_pending_q, rx_ce_q, tx_ce_q, tx_rx_q, sync_q;
  logic [DATA_W-1:0] rx_dout_q;
  logic strobe, first, wrap, rx_act, tx_act, lo, hi;
  logic [CNT_W-1:0] idx, cnt_d, last_d, adj_e, rs_e, re_e, ts_e, te_e;
  logic [CNT_W+1:0] sum;
  logic [DATA_W-1:0] rx_word;

  assign strobe = en & rx_ce_in;
  assign idx    = (state_q == RUN) ? cnt_q : '0;
  assign first  = (idx == '0);
  // a frame-start strobe sees the live register values, later strobes the shadows
  assign rs_e   = first ? rstart : rstart_q;
  assign re_e   = first ? rend : rend_q;
  assign ts_e   = first ? tstart : tstart_q;
  assign te_e   = first ? tend : tend_q;
  assign adj_e  = adj_pending_q ? adj_q : '0;
  assign sum    = {2'b00, frame_len} + {{2{adj_e[CNT_W-1]}}, adj_e};
  assign lo     = sum[CNT_W+1] || (sum == '0);
  assign hi     = sum[CNT_W];
  assign last_d = lo ? CNT_W'(1) : hi ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  // last is never 0, so the frame-start strobe can never also be the wrap strobe
  assign wrap   = !first && (idx == last_q);
  assign cnt_d  = wrap ? '0 : idx + CNT_W'(1);

  tdd_win_cmp #(.W(CNT_W)) u_rx_win (.start_i(rs_e), .end_i(re_e), .cnt_i(idx), .active_o(rx_act));
  tdd_win_cmp #(.W(CNT_W)) u_tx_win (.start_i(ts_e), .end_i(te_e), .cnt_i(idx), .active_o(tx_act));

`ifdef TDD_FRAME_TAG_EN
  assign rx_word = (idx == rs_e) ? DATA_W'(tag_word(24'(frame_no_q))) : rx_din;
`else
  assign rx_word = rx_din;
`endif

  // frame FSM, counters, shadows, adjustment latch and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      frame_no_q    <= '0;
      last_q        <= '0;
      adj_q         <= '0;
      rstart_q      <= '0;
      rend_q        <= '0;
      tstart_q      <= '0;
      tend_q        <= '0;
      adj_pending_q <= 1'b0;
      rx_ce_q       <= 1'b0;
      tx_ce_q       <= 1'b0;
      tx_rx_q       <= 1'b0;
      sync_q        <= 1'b0;
      rx_dout_q     <= '0;
    end else begin
      adj_pending_q <= adj_req | (adj_pending_q & ~(strobe & first));
      if (adj_req) adj_q <= frame_adj;
      if (!en) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        rx_ce_q <= 1'b0;
        tx_ce_q <= 1'b0;
        tx_rx_q <= 1'b0;
        sync_q  <= 1'b0;
      end else begin
        rx_ce_q <= strobe & rx_act;
        tx_ce_q <= strobe & tx_act;
        sync_q  <= strobe & first;
        if (strobe) begin
          state_q <= RUN;
          cnt_q   <= cnt_d;
          tx_rx_q <= tx_act;
          if (wrap) frame_no_q <= frame_no_q + CNT_W'(1);
          if (rx_act) rx_dout_q <= rx_word;
          if (first) begin
            rstart_q <= rstart;
            rend_q   <= rend;
            tstart_q <= tstart;
            tend_q   <= tend;
            last_q   <= last_d;
          end
        end
      end
    end
  end

  assign adj_pending = adj_pending_q;
  assign rx_ce_out   = rx_ce_q;
  assign rx_dout     = rx_dout_q;
  assign tx_ce_out   = tx_ce_q;
  assign tx_rx       = tx_rx_q;
  assign frame_sync  = sync_q;
  assign frame_no    = frame_no_q;
endmodule

// File: tb/tb_tdd_frame_gate.sv
// tb_tdd_frame_gate: randomized and directed bench for tdd_frame_gate against a frame-level reference model
module tb_tdd_frame_gate;
  logic clk = 0, rst_n = 0, en = 0, adj_req = 0, rx_ce_in = 0;
  logic [23:0] frame_len = 0, rstart = 0, rend = 0, tstart = 0, tend = 0, frame_adj = 0;
  logic [31:0] rx_din = 0;
  logic adj_pending, rx_ce_out, tx_ce_out, tx_rx, frame_sync;
  logic [31:0] rx_dout;
  logic [23:0] frame_no;
  int chk = 0, err = 0;

  typedef struct {int rs; int re; int ts; int te;} win_t;
  win_t m_w;
  int m_pos, m_period;
  logic m_pend;
  logic [23:0] m_adj, m_frame;
  logic e_rx, e_tx, e_txrx, e_sync;
  logic [31:0] e_dout;
  logic [60:0] obs, exp_v;

  assign obs   = {rx_ce_out, tx_ce_out, tx_rx, frame_sync, adj_pending, frame_no, rx_dout};
  assign exp_v = {e_rx, e_tx, e_txrx, e_sync, m_pend, m_frame, e_dout};

  tdd_frame_gate dut (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_len(frame_len), .rstart(rstart), .rend(rend),
    .tstart(tstart), .tend(tend), .frame_adj(frame_adj), .adj_req(adj_req), .adj_pending(adj_pending),
    .rx_ce_in(rx_ce_in), .rx_din(rx_din), .rx_ce_out(rx_ce_out), .rx_dout(rx_dout),
    .tx_ce_out(tx_ce_out), .tx_rx(tx_rx), .frame_sync(frame_sync), .frame_no(frame_no)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_w = '{0, 0, 0, 0};
    m_pos = 0; m_period = 1; m_pend = 0; m_adj = 0; m_frame = 0;
    e_rx = 0; e_tx = 0; e_txrx = 0; e_sync = 0; e_dout = 0;
  endtask

  // predicts the outputs after the coming clock edge from the inputs currently applied
  task automatic model_step();
    bit consume;
    int len;
    consume = 0;
    if (!en) begin
      m_pos = 0; e_rx = 0; e_tx = 0; e_txrx = 0; e_sync = 0;
    end else begin
      e_rx = 0; e_tx = 0; e_sync = 0;
      if (rx_ce_in) begin
        if (m_pos == 0) begin
          m_w = '{int'(rstart), int'(rend), int'(tstart), int'(tend)};
          len = int'(frame_len) + (m_pend ? int'($signed(m_adj)) : 0);
          len = (len < 1) ? 1 : (len > 16777215) ? 16777215 : len;
          m_period = len + 1;
          consume = m_pend;
        end
        e_rx = (m_pos >= m_w.rs) && (m_pos < m_w.re);
        e_tx = (m_pos >= m_w.ts) && (m_pos < m_w.te);
        e_txrx = e_tx;
        e_sync = (m_pos == 0);
`ifdef TDD_FRAME_TAG_EN
        if (e_rx) e_dout = (m_pos == m_w.rs) ? {8'hA5, m_frame} : rx_din;
`else
        if (e_rx) e_dout = rx_din;
`endif
        m_pos++;
        if (m_pos == m_period) begin m_pos = 0; m_frame++; end
      end
    end
    if (consume) m_pend = 0;
    if (adj_req) begin m_pend = 1; m_adj = frame_adj; end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [23:0] fl, rs, re, ts, te);
    en = 0; rx_ce_in = 0; adj_req = 0;
    step();
    frame_len = fl; rstart = rs; rend = re; tstart = ts; tend = te;
    en = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk++; if (obs !== 61'b0) begin err++; $display("FAIL reset_state got=%h exp=0", obs); end
    rst_n = 1;
    step();
    chk++; if (obs !== exp_v) begin err++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_windows();
    int syncs = 0;
    restart(9, 2, 5, 6, 9);
    rx_ce_in = 1;
    for (int i = 0; i < 30; i++) begin
      rx_din = $urandom;
      step();
      chk++; if (obs !== exp_v) begin err++; $display("FAIL windows_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      chk++;
      if ({rx_ce_out, tx_rx, frame_sync} !== {(i % 10 >= 2) && (i % 10 < 5), (i % 10 >= 6) && (i % 10 < 9), i % 10 == 0}) begin
        err++; $display("FAIL windows_pattern cyc=%0d got=%b", i, {rx_ce_out, tx_rx, frame_sync});
      end
      syncs += int'(frame_sync);
    end
    chk++; if (syncs != 3) begin err++; $display("FAIL windows_syncs got=%0d exp=3", syncs); end
  endtask

  task automatic test_adjust();
    int t[$];
    restart(9, 2, 5, 6, 9);
    rx_ce_in = 1;
    frame_adj = 24'hFFFFFD;
    for (int i = 0; i < 40; i++) begin
      adj_req = (i == 3);
      rx_din = $urandom;
      step();
      chk++; if (obs !== exp_v) begin err++; $display("FAIL adjust_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i == 9) begin chk++; if (adj_pending !== 1'b1) begin err++; $display("FAIL adjust_pending_held got=%b exp=1", adj_pending); end end
      if (i == 10) begin chk++; if (adj_pending !== 1'b0) begin err++; $display("FAIL adjust_pending_clear got=%b exp=0", adj_pending); end end
      if (frame_sync) t.push_back(i);
    end
    adj_req = 0;
    chk++;
    if (t.size() < 4 || t[1] - t[0] != 10 || t[2] - t[1] != 7 || t[3] - t[2] != 10) begin
      err++; $display("FAIL adjust_periods got=%p exp=gaps 10,7,10", t);
    end
  endtask

  task automatic test_len_change();
    int t[$];
    restart(9, 2, 5, 6, 9);
    rx_ce_in = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) frame_len = 19;
      rx_din = $urandom;
      step();
      chk++; if (obs !== exp_v) begin err++; $display("FAIL len_change_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (frame_sync) t.push_back(i);
    end
    chk++;
    if (t.size() < 3 || t[1] - t[0] != 10 || t[2] - t[1] != 20) begin
      err++; $display("FAIL len_change_periods got=%p exp=gaps 10,20", t);
    end
  endtask

  task automatic test_en_drop();
    logic [23:0] fno;
    restart(9, 2, 5, 6, 9);
    rx_ce_in = 1;
    for (int i = 0; i < 4; i++) begin
      rx_din = $urandom;
      step();
      chk++; if (obs !== exp_v) begin err++; $display("FAIL en_drop_pre cyc=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    chk++; if (rx_ce_out !== 1'b1) begin err++; $display("FAIL en_drop_inwin got=%b exp=1", rx_ce_out); end
    fno = frame_no;
    en = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk++; if ({rx_ce_out, tx_ce_out, tx_rx, frame_sync} !== 4'b0) begin err++; $display("FAIL en_drop_off cyc=%0d got=%b exp=0", i, {rx_ce_out, tx_ce_out, tx_rx, frame_sync}); end
      chk++; if (obs !== exp_v) begin err++; $display("FAIL en_drop_idle cyc=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    en = 1;
    for (int i = 0; i < 12; i++) begin
      rx_din = $urandom;
      step();
      chk++; if (obs !== exp_v) begin err++; $display("FAIL en_drop_resume cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i == 0) begin chk++; if ({frame_sync, frame_no} !== {1'b1, fno}) begin err++; $display("FAIL en_drop_restart got=%b/%0d exp=1/%0d", frame_sync, frame_no, fno); end end
    end
  endtask

  task automatic test_strobe_scale();
    int rxn = 0, txn = 0, syncs = 0;
    restart(9, 5, 5, 1, 4);
    for (int i = 0; i < 60; i++) begin
      rx_ce_in = (i % 3 == 0);
      rx_din = $urandom;
      step();
      chk++; if (obs !== exp_v) begin err++; $display("FAIL strobe_scale_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      rxn += int'(rx_ce_out); txn += int'(tx_ce_out); syncs += int'(frame_sync);
    end
    chk++; if (rxn != 0) begin err++; $display("FAIL empty_window got=%0d exp=0", rxn); end
    chk++; if (txn != 6 || syncs != 2) begin err++; $display("FAIL strobe_scale_counts got=%0d/%0d exp=6/2", txn, syncs); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        frame_len = 24'($urandom_range(0, 12));
        rstart = 24'($urandom_range(0, 14)); rend = 24'($urandom_range(0, 14));
        tstart = 24'($urandom_range(0, 14)); tend = 24'($urandom_range(0, 14));
      end
      en = ($urandom_range(0, 79) != 0);
      rx_ce_in = ($urandom_range(0, 3) != 0);
      adj_req = ($urandom_range(0, 29) == 0);
      frame_adj = 24'(int'($urandom_range(0, 24)) - 12);
      rx_din = $urandom;
      step();
      chk++; if (obs !== exp_v) begin err++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    adj_req = 0;
  endtask

  task automatic test_async_reset();
    restart(9, 0, 9, 0, 9);
    rx_ce_in = 1;
    for (int i = 0; i < 5; i++) begin rx_din = $urandom; step(); end
    chk++; if (obs !== exp_v) begin err++; $display("FAIL async_pre got=%h exp=%h", obs, exp_v); end
    #3;
    rst_n = 0;
    #1;
    chk++; if (obs !== 61'b0) begin err++; $display("FAIL async_reset got=%h exp=0", obs); end
    model_reset();
    en = 0; rx_ce_in = 0;
    #1;
    rst_n = 1;
    step();
    chk++; if (obs !== exp_v) begin err++; $display("FAIL async_release got=%h exp=%h", obs, exp_v); end
    en = 1; rx_ce_in = 1;
    for (int i = 0; i < 12; i++) begin
      rx_din = $urandom;
      step();
      chk++; if (obs !== exp_v) begin err++; $display("FAIL async_rerun cyc=%0d got=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_windows();
    test_adjust();
    test_len_change();
    test_en_drop();
    test_strobe_scale();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
